// File: rtl/bp_btb_unit.sv
// Direct-mapped BTB with saturating direction counters: same-cycle IF prediction, ID-stage
// resolution check and table update. Define BP_STATS_EN to add lookup/mispredict counters.
module bp_btb_unit #(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              res_valid,
  input  logic [ADDR_W-1:0] res_pc,
  input  logic              res_is_branch,
  input  logic              res_taken,
  input  logic [ADDR_W-1:0] res_target,
  input  logic              res_pred_taken,
  input  logic [ADDR_W-1:0] res_pred_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] correct_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0]       stat_lookups,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];

  // IF lookup: reads pre-update contents, no bypass from the ID write port.
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx      = if_pc[IDX_W+1:2];
  assign lk_tag      = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = lk_hit && cnt_q[lk_idx][CNT_W-1];
  assign pred_target = pred_taken ? target_q[lk_idx] : if_pc + ADDR_W'(4);

  // ID resolution check against what travelled with the instruction from IF.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    mispredict = 1'b0;
    if (res_valid) begin
      if (res_is_branch)
        mispredict = (res_taken != res_pred_taken) ||
                     (res_taken && (res_target != res_pred_target));
      else
        mispredict = res_pred_taken;
    end
  end

  assign correct_pc = (res_is_branch && res_taken) ? res_target : res_pc + ADDR_W'(4);

  // Update port, indexed by the resolving PC.
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             valid_we, valid_d;
  logic             cnt_we;
  logic [CNT_W-1:0] cnt_d;
  logic             entry_we;

  assign up_idx = res_pc[IDX_W+1:2];
  assign up_tag = res_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    valid_we = 1'b0;
    valid_d  = 1'b0;
    cnt_we   = 1'b0;
    cnt_d    = cnt_q[up_idx];
    entry_we = 1'b0;
    if (res_valid && !rst) begin
      if (res_is_branch && up_hit) begin
        cnt_we   = 1'b1;
        entry_we = res_taken;
        if (res_taken && (cnt_q[up_idx] != CNT_MAX))
          cnt_d = cnt_q[up_idx] + CNT_W'(1);
        else if (!res_taken && (cnt_q[up_idx] != '0))
          cnt_d = cnt_q[up_idx] - CNT_W'(1);
      end else if (res_is_branch && res_taken) begin
        valid_we = 1'b1;
        valid_d  = 1'b1;
        cnt_we   = 1'b1;
        cnt_d    = CNT_WT;
        entry_we = 1'b1;
      end else if (!res_is_branch && up_hit) begin
        valid_we = 1'b1;
        valid_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_WNT;
      end
    end else begin
      if (valid_we) valid_q[up_idx] <= valid_d;
      if (cnt_we)   cnt_q[up_idx]   <= cnt_d;
    end
  end

  // NOTE: tag/target storage is not reset; the valid bits alone qualify it, so it can map to RAM.
  always_ff @(posedge clk) begin
    if (entry_we) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= res_target;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_lookups_q, stat_mispredicts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lookups_q     <= '0;
      stat_mispredicts_q <= '0;
    end else if (res_valid) begin
      stat_lookups_q <= stat_lookups_q + 32'd1;
      if (mispredict) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  assign stat_lookups     = stat_lookups_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: doc/bp_btb_unit.md
Name: bp_btb_unit

Overview:
Parametrised branch predictor for the five-stage MIPS pipeline. It combines a direct-mapped branch target buffer with saturating direction counters and predicts next-PC in IF. Branches and jumps are still resolved in ID. The block compares each ID resolution against what was predicted for that instruction, then drives mispredict/correct_pc so the pipeline can redirect the PC and flush IF/ID.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, 2..256; IDX_W = clog2(ENTRIES)
TAG_W, 8, tag bits taken from pc[IDX_W+TAG_W+1 : IDX_W+2]
CNT_W, 2, direction counter width, 1..4
ADDR_W, 32, PC/target width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_pc  in  ADDR_W  PC being fetched
pred_taken  out  1  IF prediction (combinational)
pred_target  out  ADDR_W  predicted target; equals if_pc+4 when pred_taken=0
res_valid  in  1  ID holds a resolvable instruction; low during stall/bubble
res_pc  in  ADDR_W  PC of the ID instruction
res_is_branch  in  1  instruction is beq/bne/j
res_taken  in  1  actual outcome
res_target  in  ADDR_W  actual target when taken
res_pred_taken  in  1  prediction carried with the instruction from IF
res_pred_target  in  ADDR_W  predicted target carried from IF
mispredict  out  1  redirect request (combinational)
correct_pc  out  ADDR_W  redirect PC
stat_lookups  out  32  stats counter, present only with BP_STATS_EN
stat_mispredicts  out  32  stats counter, present only with BP_STATS_EN

Behaviour:
- Reset: synchronous on rst; the reset takes one cycle and clears all ENTRIES valid bits, sets all counters to 2^(CNT_W-1)-1 (weakly not-taken; 0 when CNT_W=1), and zeroes stats. Outputs after reset: pred_taken=0, pred_target=if_pc+4, mispredict=0 whenever res_valid=0.
- Lookup, same cycle, no latency:
  - idx = if_pc[IDX_W+1:2]; hit = valid[idx] & tag[idx]==if_pc tag field.
  - pred_taken = hit & cnt[idx] MSB; pred_target = pred_taken ? target[idx] : if_pc+4.
- Mispredict, combinational, gated by res_valid:
  - branch case: res_is_branch & (res_taken != res_pred_taken | (res_taken & res_target != res_pred_target)).
  - alias case: !res_is_branch & res_pred_taken.
  - correct_pc = (res_is_branch & res_taken) ? res_target : res_pc+4.
- Update at clk edge, only when res_valid=1; index and tag are formed from res_pc:
  - Hit, is_branch: counter +1 if taken, -1 if not, saturating at 2^CNT_W-1 and 0. Target overwritten with res_target when taken.
  - Miss, is_branch & taken: allocate. Write valid=1, tag, target, counter=2^(CNT_W-1) (weakly taken). This replaces any resident entry.
  - Miss, branch not taken: no change.
  - Hit, !is_branch (alias case): clear valid for that entry.
  - Non-branch miss: no change.
- Simultaneous lookup and update to the same idx: lookup returns the pre-update contents, with no bypass. The new contents are visible the next cycle.
- res_valid=0 (stall, flush, bubble): no table or stats change.
- rst asserted together with res_valid: reset wins and the update is discarded.
- Arithmetic: +4 and target compare are modulo 2^ADDR_W; pc bits [1:0] are ignored.
- Storage is flops or distributed RAM with one read port (IF) and one write port (ID update).

Optional Feature:
BP_STATS_EN
- Defined: stat_lookups counts every cycle with res_valid=1. stat_mispredicts counts every cycle with res_valid=1 & mispredict=1. Both are 32-bit, wrap modulo 2^32, and are cleared by rst.
- Undefined: both ports and their counters are absent.
- Prediction behaviour is identical either way.

Test Plan:
All scenarios use default parameters.
- Reset then if_pc=0x40 -> pred_taken=0, pred_target=0x44. Resolve res_pc=0x40 as non-branch -> mispredict=0.
- Cold taken branch: res_pc=0x40, taken, target 0x100, res_pred_taken=0 -> mispredict=1, correct_pc=0x100. Next cycle if_pc=0x40 -> pred_taken=1, pred_target=0x100.
- Counter saturation: same branch resolved taken 5 times, then not-taken once -> still predicts taken (cnt 3->2). A second not-taken -> cnt=1, pred_taken=0.
- Alias invalidation: table holds 0x40->0x100 and if_pc=0x40+0x1000 (same idx, different tag) -> pred_taken=0. Mispredicted non-branch at 0x40 with res_pred_taken=1 -> mispredict=1, correct_pc=0x44, entry invalidated.
- Same-cycle conflict: allocate 0x80 while if_pc=0x80 -> pred_taken=0 that cycle, 1 the next. The same allocation driven with rst high -> no entry is written.
- BP_STATS_EN: 10 resolutions with 3 mispredicts -> stat_lookups=10, stat_mispredicts=3. Cycles with res_valid=0 in between do not count.
